counter_share_ctrl: RTL and testbench



---
 rtl/counter_share_ctrl.sv | 104 ++++++++++
 tb/tb_counter_share_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/counter_share_ctrl.sv
// Round-robin controller sharing one CW-bit up-counter among NREQ requesters.
// Optional macro COUNTER_SHARE_ABORT_EN: dropping req[owner] during RUN aborts the burst.
module counter_share_ctrl #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CW   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*CW-1:0] term,
  output logic [NREQ-1:0]    gnt,
  output logic [IDW-1:0]     owner,
  output logic               busy,
  output logic               cnt_en,
  output logic [CW-1:0]      cnt_out,
  output logic [NREQ-1:0]    done
);

  typedef enum logic [1:0] {IDLE, RUN, REL} state_t;

  state_t         state, state_nx;
  logic [IDW-1:0] last_owner;
  logic [IDW-1:0] sel;
  logic [IDW-1:0] idx;
  logic           sel_vld;
  logic [CW-1:0]  term_q;
  logic           fin_q;
  logic           at_term;
  logic           abort;

  assign at_term = (cnt_out == term_q);

`ifdef COUNTER_SHARE_ABORT_EN
  assign abort = (state == RUN) && !req[owner];
`else
  assign abort = 1'b0;
`endif

  // Search upward from last_owner+1; descending loop lets the nearest hit win.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    idx     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = last_owner + IDW'(k);
      if (req[idx]) begin
        sel     = idx;
        sel_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (sel_vld) state_nx = RUN;
      RUN:     if (abort || at_term) state_nx = REL;
      REL:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= '0;
      cnt_out    <= '0;
      term_q     <= '0;
      last_owner <= IDW'(NREQ - 1);
      fin_q      <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (sel_vld) begin
            owner   <= sel;
            cnt_out <= '0;
            term_q  <= term[sel*CW +: CW];
          end
        end
        RUN: begin
          if (abort) begin
            fin_q      <= 1'b0;
            last_owner <= owner;
          end else if (at_term) begin
            fin_q      <= 1'b1;
            last_owner <= owner;
          end else begin
            cnt_out <= cnt_out + 1'b1;
          end
        end
        default: fin_q <= 1'b0;
      endcase
    end
  end

  // fin_q distinguishes a completed burst from an aborted one while in REL.
  assign gnt    = (state == RUN) ? (NREQ'(1) << owner) : '0;
  assign done   = (state == REL && fin_q) ? (NREQ'(1) << owner) : '0;
  assign busy   = (state != IDLE);
  assign cnt_en = (state == RUN);

endmodule

// File: tb/tb_counter_share_ctrl.sv
// Scoreboard bench for counter_share_ctrl: stimulus pushes expected bursts, a monitor checks them.
module tb_counter_share_ctrl;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int CW   = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    req;
  logic [NREQ*CW-1:0] term;
  logic [NREQ-1:0]    gnt;
  logic [IDW-1:0]     owner;
  logic               busy;
  logic               cnt_en;
  logic [CW-1:0]      cnt_out;
  logic [NREQ-1:0]    done;

  counter_share_ctrl #(.NREQ(NREQ), .IDW(IDW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .req(req), .term(term), .gnt(gnt), .owner(owner),
    .busy(busy), .cnt_en(cnt_en), .cnt_out(cnt_out), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { int own; int tv; } exp_t;
  exp_t q[$];

  int n_chk  = 0;
  int n_pass = 0;
  int last   = NREQ - 1;
  logic mon_en = 1'b1;
  logic in_burst = 1'b0;
  int run_len = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int lst);
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (lst + k) % NREQ;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  // Monitor: follows each grant, checks the count ramp and the closing done pulse.
  always @(negedge clk) begin
    if (!reset) begin
      in_burst = 1'b0;
    end else if (mon_en) begin
      if (gnt != 0) begin
        if (!in_burst) begin
          in_burst = 1'b1;
          run_len  = 0;
          if (q.size() == 0) chk("unexpected_grant", 32'(gnt), 0);
          else begin
            chk("grant_vec", 32'(gnt), 32'(1) << q[0].own);
            chk("owner", 32'(owner), 32'(q[0].own));
          end
        end
        chk("ramp", 32'(cnt_out), 32'(run_len));
        chk("cnt_en", 32'(cnt_en), 1);
        run_len++;
      end
      if (done != 0) begin
        if (q.size() == 0) chk("unexpected_done", 32'(done), 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("done_vec", 32'(done), 32'(1) << e.own);
          chk("final_cnt", 32'(cnt_out), 32'(e.tv));
          chk("burst_len", 32'(run_len), 32'(e.tv + 1));
          chk("gnt_in_rel", 32'(gnt), 0);
          chk("busy_in_rel", 32'(busy), 1);
        end
        in_burst = 1'b0;
      end
    end
  end

  // Called at a negedge in IDLE; returns at the negedge after release with the DUT idle again.
  task automatic issue(input logic [NREQ-1:0] r, input logic [NREQ*CW-1:0] t);
    exp_t e;
    int s;
    s = rr_pick(r, last);
    req  = r;
    term = t;
    if (s < 0) begin
      @(negedge clk);
      chk("idle_busy", 32'(busy), 0);
      return;
    end
    e.own = s;
    e.tv  = int'((t >> (s * CW)) & ((1 << CW) - 1));
    q.push_back(e);
    @(negedge clk);
    // Changes after grant must be ignored (owner bit kept so an abort build also completes).
    req  = NREQ'($urandom) | (NREQ'(1) << s);
    term = (NREQ*CW)'($urandom);
    repeat (e.tv + 2) @(negedge clk);
    req  = '0;
    last = s;
    chk("busy_after_rel", 32'(busy), 0);
    chk("done_after_rel", 32'(done), 0);
  endtask

  initial begin
    reset = 1'b0;
    req   = '1;
    term  = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt_en", 32'(cnt_en), 0);
    chk("rst_cnt_out", 32'(cnt_out), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_owner", 32'(owner), 0);
    req   = '0;
    reset = 1'b1;
    @(negedge clk);

    issue(4'b0001, 8'h03);
    for (int i = 0; i < 5; i++) issue(4'b1111, 8'h00);
    issue(4'b0100, 8'h00);
    issue(4'b0101, 8'h00);

    // Reset in the middle of a burst: no done, pointer restored.
    begin
      exp_t e;
      e.own = 1; e.tv = 3;
      q.push_back(e);
      req  = 4'b0010;
      term = 8'h0C;
      repeat (3) @(negedge clk);
      chk("mid_cnt", 32'(cnt_out), 2);
      reset = 1'b0;
      @(negedge clk);
      chk("mr_gnt", 32'(gnt), 0);
      chk("mr_busy", 32'(busy), 0);
      chk("mr_cnt_out", 32'(cnt_out), 0);
      chk("mr_done", 32'(done), 0);
      chk("mr_owner", 32'(owner), 0);
      q.delete();
      reset = 1'b1;
      req   = '0;
      last  = NREQ - 1;
      @(negedge clk);
    end
    issue(4'b0011, 8'h0F);

`ifdef COUNTER_SHARE_ABORT_EN
    mon_en = 1'b0;
    req  = 4'b0001;
    term = 8'h03;
    repeat (2) @(negedge clk);
    chk("ab_cnt", 32'(cnt_out), 1);
    req = '0;
    @(negedge clk);
    chk("ab_busy", 32'(busy), 1);
    chk("ab_gnt", 32'(gnt), 0);
    chk("ab_hold", 32'(cnt_out), 1);
    chk("ab_done", 32'(done), 0);
    @(negedge clk);
    chk("ab_idle", 32'(busy), 0);
    last   = 0;
    mon_en = 1'b1;
`endif

    for (int n = 0; n < 60; n++) begin
      logic [NREQ-1:0] r;
      r = NREQ'($urandom);
      if ($urandom_range(0, 5) == 0) r = '0;
      issue(r, (NREQ*CW)'($urandom));
    end

    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 0);
    chk("final_idle", 32'(busy), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
